// File: rtl/pps_pll_pkg.sv
// Shared definitions for the PPS-disciplined PLL front end: the detector
// state encoding, default measurement constants and the hold word.
package pps_pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;

  localparam int FREQ_WIDTH    = 32;
  localparam int CNT_WIDTH     = 26;
  localparam int NOMINAL_COUNT = 10_000_000;
  localparam int WINDOW_MIN    = 31_990_000;
  localparam int WINDOW_MAX    = 32_010_000;
  localparam int GAIN_SHIFT    = 7;
  localparam int ERR_LIMIT     = 1024;

  // Output word meaning "no valid measurement, freeze the filter".
  localparam int HOLD_WORD     = 0;

endpackage

// File: rtl/pps_sync.sv
// Optional N-stage synchronizer followed by a registered rising-edge detect.
// pDepth=2 for the asynchronous PPS input, pDepth=0 for signals already in
// the clk domain (the pulse is then the edge of the raw input).
module pps_sync #(
  parameter int pDepth = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_pulse
);

  logic w_level;
  logic r_prev;

  if (pDepth > 0) begin : g_sync
    logic [pDepth-1:0] r_sync;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= i_in;
        for (int i = 1; i < pDepth; i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
    end

    assign w_level = r_sync[pDepth-1];
  end else begin : g_bypass
    assign w_level = i_in;
  end

  // Remember the previous level for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_pulse = w_level & ~r_prev;

endmodule

// File: rtl/pps_freq_detector.sv
// Counts NCO rising edges between accepted PPS edges, turns the deviation
// from the nominal count into a corrected frequency word and strobes it into
// the loop filter. A word of 0 means hold (PPS lost).
// Optional lock detector enabled by defining PPS_LOCK_DETECT_EN.
module pps_freq_detector
  import pps_pll_pkg::*;
#(
  parameter int pWidth        = FREQ_WIDTH,
  parameter int pCntWidth     = CNT_WIDTH,
  parameter int pNominalCount = NOMINAL_COUNT,
  parameter int pWindowMin    = WINDOW_MIN,
  parameter int pWindowMax    = WINDOW_MAX,
  parameter int pGainShift    = GAIN_SHIFT,
  parameter int pErrLimit     = ERR_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pps,
  input  logic              i_nco_msb,
  input  logic [pWidth-1:0] i_freq_word,
  output logic [pWidth-1:0] o_out,
  output logic              o_ce,
  output logic              o_pps_missing,
  output logic              o_locked
);

  // One guard bit above the sign keeps the sum from wrapping even for an
  // out-of-range feedback word.
  localparam int lp_sum_w = pWidth + 2;

  localparam logic [pCntWidth-1:0]      lp_win_min  = pCntWidth'(pWindowMin);
  localparam logic [pCntWidth-1:0]      lp_win_max  = pCntWidth'(pWindowMax);
  localparam logic signed [pCntWidth:0] lp_nominal  = (pCntWidth+1)'(pNominalCount);
  localparam logic signed [pCntWidth:0] lp_err_lim  = (pCntWidth+1)'(pErrLimit);
  localparam logic signed [lp_sum_w-1:0] lp_word_min = lp_sum_w'(1);
  localparam logic signed [lp_sum_w-1:0] lp_word_max = $signed({3'b000, {(pWidth-1){1'b1}}});

  state_t                   r_state;
  state_t                   w_state_next;
  logic [pCntWidth-1:0]     r_int_cnt;
  logic [pCntWidth-1:0]     r_edge_cnt;
  logic [pWidth-1:0]        r_out;
  logic                     r_ce;
  logic                     r_missing;
  logic                     w_pps_edge;
  logic                     w_nco_edge;
  logic                     w_timeout;
  logic                     w_accept;
  logic signed [pCntWidth:0]  w_err;
  logic signed [pCntWidth:0]  w_err_clamp;
  logic signed [lp_sum_w-1:0] w_err_wide;
  logic signed [lp_sum_w-1:0] w_sum;
  logic [pWidth-1:0]        w_word_sat;

  pps_sync #(.pDepth(2)) u_pps_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_in    (i_pps),
    .o_pulse (w_pps_edge)
  );

  pps_sync #(.pDepth(0)) u_nco_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_in    (i_nco_msb),
    .o_pulse (w_nco_edge)
  );

  assign w_timeout = (r_int_cnt >= lp_win_max);
  assign w_accept  = w_pps_edge && (r_int_cnt >= lp_win_min);

  // Count error -> clamp -> scale -> add to feedback -> saturate to 1..max.
  always_comb begin
    w_err       = lp_nominal - $signed({1'b0, r_edge_cnt});
    w_err_clamp = w_err;
    if (w_err > lp_err_lim) begin
      w_err_clamp = lp_err_lim;
    end else if (w_err < -lp_err_lim) begin
      w_err_clamp = -lp_err_lim;
    end
    w_err_wide = $signed({{(lp_sum_w-pCntWidth-1){w_err_clamp[pCntWidth]}}, w_err_clamp});
    w_sum      = $signed({2'b00, i_freq_word}) + (w_err_wide <<< pGainShift);
    if (w_sum < lp_word_min) begin
      w_word_sat = pWidth'(1);
    end else if (w_sum > lp_word_max) begin
      w_word_sat = lp_word_max[pWidth-1:0];
    end else begin
      w_word_sat = w_sum[pWidth-1:0];
    end
  end

  // Next-state selection for the measurement FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_pps_edge) w_state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else if (w_accept) begin
          w_state_next = ST_COMPUTE;
        end
      end
      ST_COMPUTE: w_state_next = ST_MEASURE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Interval and NCO-edge counters; COMPUTE counts as the first cycle of the
  // next window so consecutive windows have no gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_int_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pps_edge) begin
            r_int_cnt  <= '0;
            r_edge_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (r_int_cnt < lp_win_max) r_int_cnt <= r_int_cnt + pCntWidth'(1);
          if (w_nco_edge && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + pCntWidth'(1);
        end
        ST_COMPUTE: begin
          r_int_cnt  <= pCntWidth'(1);
          r_edge_cnt <= pCntWidth'(w_nco_edge);
        end
        default: ;
      endcase
    end
  end

  // Result word, strobe and sticky PPS-missing flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out     <= pWidth'(HOLD_WORD);
      r_ce      <= 1'b0;
      r_missing <= 1'b0;
    end else begin
      r_ce <= 1'b0;
      if ((r_state == ST_MEASURE) && w_timeout) begin
        r_out     <= pWidth'(HOLD_WORD);
        r_ce      <= 1'b1;
        r_missing <= 1'b1;
      end else if (r_state == ST_COMPUTE) begin
        r_out     <= w_word_sat;
        r_ce      <= 1'b1;
        r_missing <= 1'b0;
      end
    end
  end

`ifdef PPS_LOCK_DETECT_EN
  localparam logic signed [pCntWidth:0] lp_lock_tol = (pCntWidth+1)'(2);

  logic [3:0] r_lock_cnt;
  logic       w_err_small;

  assign w_err_small = (w_err <= lp_lock_tol) && (w_err >= -lp_lock_tol);

  // Count consecutive near-perfect windows; any large error or timeout restarts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_cnt <= 4'd0;
    end else if ((r_state == ST_MEASURE) && w_timeout) begin
      r_lock_cnt <= 4'd0;
    end else if (r_state == ST_COMPUTE) begin
      if (!w_err_small) begin
        r_lock_cnt <= 4'd0;
      end else if (r_lock_cnt != 4'hF) begin
        r_lock_cnt <= r_lock_cnt + 4'd1;
      end
    end
  end

  assign o_locked = r_lock_cnt[3];
`else
  assign o_locked = 1'b0;
`endif

  assign o_out         = r_out;
  assign o_ce          = r_ce;
  assign o_pps_missing = r_missing;

endmodule

// File: tb/tb_pps_freq_detector.sv
// Directed bench for pps_freq_detector with a scaled-down window
// (100 nominal edges per 320 clk). Expected results are queued when the
// closing PPS is driven and checked when CE appears. The error clamp is
// lowered to 64 so a zero-edge window actually exercises it.
module tb_pps_freq_detector;

  localparam int NOM  = 100;
  localparam int WMIN = 300;
  localparam int WMAX = 340;
  localparam int GS   = 7;
  localparam int LIM  = 64;
`ifdef PPS_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps = 1'b0;
  logic        nco = 1'b0;
  logic [31:0] fw  = 32'h5000_0000;
  logic [31:0] o_out;
  logic        o_ce;
  logic        o_pps_missing;
  logic        o_locked;

  pps_freq_detector #(
    .pWidth(32), .pCntWidth(26), .pNominalCount(NOM), .pWindowMin(WMIN),
    .pWindowMax(WMAX), .pGainShift(GS), .pErrLimit(LIM)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pps         (pps),
    .i_nco_msb     (nco),
    .i_freq_word   (fw),
    .o_out         (o_out),
    .o_ce          (o_ce),
    .o_pps_missing (o_pps_missing),
    .o_locked      (o_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] out;
    logic        missing;
    logic        locked;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bench-side view of the detector.
  bit measuring = 1'b0;
  int win_edges = 0;
  int last_pps  = 0;
  int lock_cnt  = 0;
  bit prev_ce   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] f, input int n);
    longint e;
    longint s;
    e = longint'(NOM - n);
    if (e > LIM) e = LIM;
    if (e < -LIM) e = -LIM;
    s = longint'(f) + e * (longint'(1) << GS);
    if (s < 1) s = 1;
    if (s > 64'h7FFF_FFFF) s = 64'h7FFF_FFFF;
    return 32'(s);
  endfunction

  task automatic push_compute();
    exp_t e;
    int   err;
    err = NOM - win_edges;
    if (err <= 2 && err >= -2) begin
      if (lock_cnt < 15) lock_cnt++;
    end else begin
      lock_cnt = 0;
    end
    e.out     = model_word(fw, win_edges);
    e.missing = 1'b0;
    e.locked  = LOCK_EN && (lock_cnt >= 8);
    e.due     = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One PPS period: PPS pulse at offset 0 (closing the previous window),
  // n NCO edges well inside the window, optional glitch pulse.
  task automatic run_window(input int n, input int glitch_at, input logic [31:0] f, input int len);
    int per;
    per = (n > 100) ? 2 : 3;
    for (int i = 0; i < len; i++) begin
      step();
      if (i == 0) begin
        if (measuring) push_compute();
        measuring = 1'b1;
        win_edges = n;
        last_pps  = cyc;
      end
      pps = (i < 5) || (glitch_at > 0 && i >= glitch_at && i < glitch_at + 3);
      if (i == 10) fw = f;
      nco = (i >= 8) && (((i - 8) % per) == 0) && (((i - 8) / per) < n);
    end
  endtask

  task automatic run_gap(input int len);
    exp_t e;
    pps = 1'b0;
    nco = 1'b0;
    if (measuring) begin
      lock_cnt  = 0;
      e.out     = 32'h0;
      e.missing = 1'b1;
      e.locked  = 1'b0;
      e.due     = last_pps + 4 + WMAX;
      sb.push_back(e);
      measuring = 1'b0;
    end
    for (int i = 0; i < len; i++) step();
  endtask

  // Scoreboard monitor: every CE must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_ce) begin
        chk("ce_back_to_back", 32'(prev_ce), 32'h0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL unexpected_ce: observed CE with out=%h, expected no CE (cycle %0d)", o_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("ce_cycle", 32'(cyc), 32'(e.due));
          chk("out_word", o_out, e.out);
          chk("pps_missing", 32'(o_pps_missing), 32'(e.missing));
          chk("locked", 32'(o_locked), 32'(e.locked));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        n_cmp++;
        n_bad++;
        $error("FAIL ce_missing: observed no CE by cycle %0d, expected CE at cycle %0d", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
    prev_ce = o_ce;
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("reset_out", o_out, 32'h0);
    chk("reset_ce", 32'(o_ce), 32'h0);
    chk("reset_missing", 32'(o_pps_missing), 32'h0);
    chk("reset_locked", 32'(o_locked), 32'h0);
    rst = 1'b0;
    repeat (5) step();

    // Nominal count: first PPS only opens a window
    run_window(100, 0, 32'h5000_0000, 320);
    run_window(100, 0, 32'h5000_0000, 320);
    // Slow / fast NCO
    run_window(98, 0, 32'h5000_0000, 320);
    run_window(103, 0, 32'h5000_0000, 320);
    // Glitch PPS inside the window is ignored
    run_window(100, 150, 32'h5000_0000, 320);
    run_window(100, 0, 32'h5000_0000, 320);

    // PPS lost: timeout gives hold word and sticky missing flag
    run_gap(60);
    chk("timeout_out_held", o_out, 32'h0);
    chk("timeout_missing", 32'(o_pps_missing), 32'h1);
    run_window(100, 0, 32'h5000_0000, 320);
    chk("missing_sticky_idle", 32'(o_pps_missing), 32'h1);
    run_window(0, 0, 32'h5000_0000, 320);

    // Clamp and saturation
    run_window(0, 0, 32'h7FFF_FF00, 320);
    run_window(150, 0, 32'h0000_0010, 320);
    run_window(100, 0, 32'h5000_0000, 320);

    // Asynchronous reset mid-window
    run_window(100, 0, 32'h5000_0000, 100);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", o_out, 32'h0);
    chk("async_rst_ce", 32'(o_ce), 32'h0);
    chk("async_rst_missing", 32'(o_pps_missing), 32'h0);
    chk("async_rst_locked", 32'(o_locked), 32'h0);
    measuring = 1'b0;
    lock_cnt  = 0;
    step();
    step();
    #3;
    rst = 1'b0;
    repeat (400) step();

    // Lock detection: 8 perfect windows, then a 5-count error
    for (int w = 0; w < 9; w++) run_window(100, 0, 32'h5000_0000, 320);
    run_window(95, 0, 32'h5000_0000, 320);
    run_window(100, 0, 32'h5000_0000, 320);
    repeat (20) step();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    chk("final_locked", 32'(o_locked), 32'(LOCK_EN && (lock_cnt >= 8)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
